// File: rtl/sram_bridge_pkg.sv
// Shared constants and channel state type for the banked SRAM request bridge.
package sram_bridge_pkg;

  localparam int NUM_BANKS  = 8;
  localparam int NUM_WMASKS = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 9;
  localparam int BANK_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HOLD
  } chan_state_e;

endpackage

// File: rtl/sram_bridge_chan.sv
// One valid/ready channel onto one port of every bank macro: decode, FSM, hold register.
// Range checking is compiled in with `define SRAM_BRIDGE_ERR_EN.
module sram_bridge_chan
  import sram_bridge_pkg::*;
#(
  parameter bit          WRITE_EN  = 1'b1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             run_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [31:0]                      req_addr_i,
  input  logic                             req_we_i,
  input  logic [NUM_WMASKS-1:0]            req_wstrb_i,
  input  logic [DATA_WIDTH-1:0]            req_wdata_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             rsp_err_o,
  output logic [NUM_BANKS-1:0]             sram_csb_o,
  output logic [NUM_BANKS-1:0]             sram_web_o,
  output logic [NUM_BANKS*NUM_WMASKS-1:0]  sram_wmask_o,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]  sram_addr_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  sram_din_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  sram_dout_i
);

  chan_state_e           state_q, state_d;
  logic [BANK_SEL_W-1:0] bank_q, bank_d, req_bank;
  logic [ADDR_WIDTH-1:0] req_word;
  logic                  zero_q, zero_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] hold_rdata_q, hold_rdata_d;
  logic                  hold_err_q, hold_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  in_range, accept, is_write;
  logic                  unused_addr_bits;

  assign req_bank = req_addr_i[13:11];
  assign req_word = req_addr_i[10:2];
  assign is_write = WRITE_EN & req_we_i;

`ifdef SRAM_BRIDGE_ERR_EN
  assign in_range         = (req_addr_i[31:14] == BASE_ADDR[31:14]);
  assign unused_addr_bits = ^req_addr_i[1:0];
`else
  // Without the range check the window simply aliases every 16 KiB.
  assign in_range         = 1'b1;
  assign unused_addr_bits = ^{req_addr_i[31:14], req_addr_i[1:0]};
`endif

  // Writes and rejected accesses answer with zero data.
  assign resp_rdata = zero_q ? '0 : sram_dout_i[bank_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_d      = state_q;
    bank_d       = bank_q;
    zero_d       = zero_q;
    err_d        = err_q;
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_rdata_o  = '0;
    rsp_err_o    = 1'b0;
    unique case (state_q)
      IDLE: req_ready_o = run_i;
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = resp_rdata;
        rsp_err_o   = err_q;
        req_ready_o = rsp_ready_i;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d      = HOLD;
          hold_rdata_d = resp_rdata;
          hold_err_d   = err_q;
        end
      end
      HOLD: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = hold_rdata_q;
        rsp_err_o   = hold_err_q;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = req_valid_i & req_ready_o;
    if (accept) begin
      state_d = RESP;
      bank_d  = req_bank;
      zero_d  = is_write | ~in_range;
      err_d   = ~in_range;
    end
  end

  // The accepted request reaches its macro in the same cycle it is accepted.
  always_comb begin
    sram_csb_o   = '1;
    sram_web_o   = '1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (accept && in_range && run_i) begin
      sram_csb_o[req_bank]                           = 1'b0;
      sram_addr_o[req_bank*ADDR_WIDTH +: ADDR_WIDTH] = req_word;
      if (is_write) begin
        sram_web_o[req_bank]                           = 1'b0;
        sram_wmask_o[req_bank*NUM_WMASKS +: NUM_WMASKS] = req_wstrb_i;
        sram_din_o[req_bank*DATA_WIDTH +: DATA_WIDTH]   = req_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      bank_q       <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      // NOTE: the hold register is a few flops, not a memory, so it is reset to keep rdata at 0.
      hold_rdata_q <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      bank_q       <= bank_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
      hold_rdata_q <= hold_rdata_d;
      hold_err_q   <= hold_err_d;
    end
  end

endmodule

// File: rtl/sram_bank_bridge.sv
// Data (read/write, macro port 0) and fetch (read-only, macro port 1) channels onto the banked SRAM.
// Optional out-of-range error reporting: `define SRAM_BRIDGE_ERR_EN.
module sram_bank_bridge
  import sram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             d_req_valid,
  output logic                             d_req_ready,
  input  logic [31:0]                      d_req_addr,
  input  logic                             d_req_we,
  input  logic [NUM_WMASKS-1:0]            d_req_wstrb,
  input  logic [DATA_WIDTH-1:0]            d_req_wdata,
  output logic                             d_rsp_valid,
  input  logic                             d_rsp_ready,
  output logic [DATA_WIDTH-1:0]            d_rsp_rdata,
  output logic                             d_rsp_err,
  input  logic                             f_req_valid,
  output logic                             f_req_ready,
  input  logic [31:0]                      f_req_addr,
  output logic                             f_rsp_valid,
  input  logic                             f_rsp_ready,
  output logic [DATA_WIDTH-1:0]            f_rsp_rdata,
  output logic                             f_rsp_err,
  output logic [NUM_BANKS-1:0]             sram_clk0,
  output logic [NUM_BANKS-1:0]             sram_csb0,
  output logic [NUM_BANKS-1:0]             sram_web0,
  output logic [NUM_BANKS*NUM_WMASKS-1:0]  sram_wmask0,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]  sram_addr0,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  sram_din0,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  sram_dout0,
  output logic [NUM_BANKS-1:0]             sram_clk1,
  output logic [NUM_BANKS-1:0]             sram_csb1,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]  sram_addr1,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  sram_dout1
);

  logic                            run_q;
  logic [NUM_BANKS-1:0]            f_unused_web;
  logic [NUM_BANKS*NUM_WMASKS-1:0] f_unused_wmask;
  logic [NUM_BANKS*DATA_WIDTH-1:0] f_unused_din;

  assign sram_clk0 = {NUM_BANKS{clk_i}};
  assign sram_clk1 = {NUM_BANKS{clk_i}};

  // Holds both channels off for the first cycle after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  sram_bridge_chan #(.WRITE_EN(1'b1), .BASE_ADDR(BASE_ADDR)) u_data_chan (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .run_i        (run_q),
    .req_valid_i  (d_req_valid),
    .req_ready_o  (d_req_ready),
    .req_addr_i   (d_req_addr),
    .req_we_i     (d_req_we),
    .req_wstrb_i  (d_req_wstrb),
    .req_wdata_i  (d_req_wdata),
    .rsp_valid_o  (d_rsp_valid),
    .rsp_ready_i  (d_rsp_ready),
    .rsp_rdata_o  (d_rsp_rdata),
    .rsp_err_o    (d_rsp_err),
    .sram_csb_o   (sram_csb0),
    .sram_web_o   (sram_web0),
    .sram_wmask_o (sram_wmask0),
    .sram_addr_o  (sram_addr0),
    .sram_din_o   (sram_din0),
    .sram_dout_i  (sram_dout0)
  );

  // Port 1 has no write side, so the fetch channel's write outputs go nowhere.
  sram_bridge_chan #(.WRITE_EN(1'b0), .BASE_ADDR(BASE_ADDR)) u_fetch_chan (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .run_i        (run_q),
    .req_valid_i  (f_req_valid),
    .req_ready_o  (f_req_ready),
    .req_addr_i   (f_req_addr),
    .req_we_i     (1'b0),
    .req_wstrb_i  ('0),
    .req_wdata_i  ('0),
    .rsp_valid_o  (f_rsp_valid),
    .rsp_ready_i  (f_rsp_ready),
    .rsp_rdata_o  (f_rsp_rdata),
    .rsp_err_o    (f_rsp_err),
    .sram_csb_o   (sram_csb1),
    .sram_web_o   (f_unused_web),
    .sram_wmask_o (f_unused_wmask),
    .sram_addr_o  (sram_addr1),
    .sram_din_o   (f_unused_din),
    .sram_dout_i  (sram_dout1)
  );

endmodule
